// File: rtl/skyhop_timer_pkg.sv
// Shared definitions for the SkyHop round countdown timer.
package skyhop_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    localparam int MAX_SECONDS = 99;
    localparam int BCD_W       = 4;

    // Clamp an 8-bit intermediate count to the displayable range.
    function automatic logic [6:0] sat_to_max(input logic [7:0] value);
        if (value > 8'(MAX_SECONDS))
            return 7'(MAX_SECONDS);
        return value[6:0];
    endfunction

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational 7-bit binary (0..99) to two-digit BCD converter.
module bin2bcd_99
    import skyhop_timer_pkg::*;
(
    input  logic [6:0]       i_bin,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones
);

    logic [BCD_W-1:0] w_tens;

    // Compare ladder instead of a divider: the highest threshold reached gives the tens digit.
    always_comb begin
        w_tens = '0;
        for (int k = 1; k <= 9; k++) begin
            if (i_bin >= 7'(k * 10))
                w_tens = BCD_W'(k);
        end
    end

    assign o_tens = w_tens;
    assign o_ones = BCD_W'(i_bin - 7'(w_tens) * 7'd10);

endmodule

// File: rtl/game_countdown_timer.sv
// SkyHop round countdown timer: counts seconds down to zero with start/pause/bonus
// control, BCD readout, low-time warning and a single-cycle expiry pulse.
module game_countdown_timer #(
    parameter int START_SECONDS = 60,
    parameter int BONUS_SECONDS = 5,
    parameter int WARN_SECONDS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_sec_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       add_bonus,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       running,
    output logic       warning,
    output logic       time_up
);
    import skyhop_timer_pkg::*;

    // state      | meaning
    // ST_IDLE    | count held at START_SECONDS, waiting for start
    // ST_RUN     | counting down on each tick, bonus accepted
    // ST_PAUSED  | ticks ignored, bonus accepted, pause resumes
    // ST_EXPIRED | count is zero, waiting for start

    localparam logic [6:0] START_7 = 7'(START_SECONDS);
    localparam logic [7:0] BONUS_8 = 8'(BONUS_SECONDS);
    localparam logic [6:0] WARN_7  = 7'(WARN_SECONDS);

    timer_state_t r_state;
    timer_state_t w_next_state;
    logic [6:0]   r_count;
    logic [6:0]   w_next_count;
    logic         r_running;
    logic         r_warning;
    logic         r_time_up;
    logic         w_next_running;
    logic         w_next_warning;
    logic         w_next_time_up;
    logic [7:0]   w_bonus_add;
    logic [6:0]   w_run_count;
    logic [6:0]   w_pause_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= START_7;
            r_running <= 1'b0;
            r_warning <= 1'b0;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_next_count;
            r_running <= w_next_running;
            r_warning <= w_next_warning;
            r_time_up <= w_next_time_up;
        end
    end

    // Tick and bonus are combined in 8 bits before clamping so 99 - 1 + bonus saturates correctly.
    always_comb begin
        w_bonus_add   = add_bonus ? BONUS_8 : 8'd0;
        w_run_count   = sat_to_max({1'b0, r_count} - {7'd0, one_sec_tick} + w_bonus_add);
        w_pause_count = sat_to_max({1'b0, r_count} + w_bonus_add);
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_count   = r_count;
        w_next_time_up = 1'b0;

        if (start) begin
            w_next_state = ST_RUN;
            w_next_count = START_7;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    w_next_count = w_run_count;
                    if (w_run_count == 7'd0) begin
                        w_next_state   = ST_EXPIRED;
                        w_next_time_up = 1'b1;
                    end else if (pause) begin
                        w_next_state = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    w_next_count = w_pause_count;
                    if (pause)
                        w_next_state = ST_RUN;
                end
                ST_EXPIRED: w_next_count = 7'd0;
                default:    w_next_count = START_7;
            endcase
        end

        w_next_running = (w_next_state == ST_RUN);
        w_next_warning = ((w_next_state == ST_RUN) || (w_next_state == ST_PAUSED)) &&
                         (w_next_count != 7'd0) && (w_next_count <= WARN_7);
    end

    bin2bcd_99 u_bin2bcd (
        .i_bin  (r_count),
        .o_tens (time_tens),
        .o_ones (time_ones)
    );

    assign running = r_running;
    assign warning = r_warning;
    assign time_up = r_time_up;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer with default parameters (60 / 5 / 10).
module tb_game_countdown_timer;

    logic       clk;
    logic       rst;
    logic       one_sec_tick;
    logic       start;
    logic       pause;
    logic       add_bonus;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic       running;
    logic       warning;
    logic       time_up;

    int n_vec;
    int n_err;

    // Expected output word: {tens, ones, running, warning, time_up}.
    logic [10:0] sb_q[$];

    // Reference model: 0 idle, 1 run, 2 paused, 3 expired.
    int m_state;
    int m_cnt;
    int m_tu;

    game_countdown_timer dut (
        .clk          (clk),
        .rst          (rst),
        .one_sec_tick (one_sec_tick),
        .start        (start),
        .pause        (pause),
        .add_bonus    (add_bonus),
        .time_tens    (time_tens),
        .time_ones    (time_ones),
        .running      (running),
        .warning      (warning),
        .time_up      (time_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got tens=%0d ones=%0d run=%0b warn=%0b tu=%0b, want tens=%0d ones=%0d run=%0b warn=%0b tu=%0b",
                     tag, obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
                     exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [10:0] model_word();
        logic [3:0] t;
        logic [3:0] o;
        logic       w;
        t = 4'(m_cnt / 10);
        o = 4'(m_cnt % 10);
        w = (m_state == 1 || m_state == 2) && m_cnt > 0 && m_cnt <= 10;
        return {t, o, (m_state == 1), w, (m_tu != 0)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 60;
        m_tu    = 0;
    endtask

    task automatic model_step(input logic tk, input logic st, input logic pa, input logic bo);
        int c;
        m_tu = 0;
        if (st) begin
            m_state = 1;
            m_cnt   = 60;
        end else if (m_state == 1) begin
            c = m_cnt - (tk ? 1 : 0) + (bo ? 5 : 0);
            m_cnt = (c > 99) ? 99 : c;
            if (m_cnt == 0) begin
                m_state = 3;
                m_tu    = 1;
            end else if (pa) begin
                m_state = 2;
            end
        end else if (m_state == 2) begin
            c = m_cnt + (bo ? 5 : 0);
            m_cnt = (c > 99) ? 99 : c;
            if (pa) m_state = 1;
        end
    endtask

    function automatic logic [10:0] dut_word();
        return {time_tens, time_ones, running, warning, time_up};
    endfunction

    task automatic pop_check(input string tag);
        logic [10:0] e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h, want an entry", tag, dut_word());
        end else begin
            e = sb_q.pop_front();
            chk(tag, dut_word(), e);
        end
    endtask

    // One clock of stimulus: drive after negedge, predict, check #1 after posedge.
    task automatic cyc(input string tag, input logic tk, input logic st, input logic pa, input logic bo);
        @(negedge clk);
        one_sec_tick = tk;
        start        = st;
        pause        = pa;
        add_bonus    = bo;
        model_step(tk, st, pa, bo);
        sb_q.push_back(model_word());
        @(posedge clk);
        #1;
        one_sec_tick = 1'b0;
        start        = 1'b0;
        pause        = 1'b0;
        add_bonus    = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        one_sec_tick = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        add_bonus = 1'b0;
        model_reset();

        #12;
        sb_q.push_back(model_word());
        pop_check("reset");
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores tick, pause and bonus
        for (int i = 0; i < 3; i++) cyc("idle_tick", 1, 0, 0, 0);
        cyc("idle_pause", 0, 0, 1, 0);
        cyc("idle_bonus", 0, 0, 0, 1);

        // full countdown to expiry
        cyc("start", 0, 1, 0, 0);
        for (int i = 0; i < 60; i++) cyc("countdown", 1, 0, 0, 0);
        cyc("exp_hold", 0, 0, 0, 0);
        cyc("exp_tick", 1, 0, 0, 0);
        cyc("exp_bonus", 0, 0, 0, 1);
        cyc("exp_pause", 0, 0, 1, 0);

        // pause/resume at 42
        cyc("restart", 0, 1, 0, 0);
        for (int i = 0; i < 18; i++) cyc("to42", 1, 0, 0, 0);
        cyc("pause_on", 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc("paused_tick", 1, 0, 0, 0);
        cyc("pause_off", 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc("resumed", 1, 0, 0, 0);

        // bonus while paused, then saturation from 97
        cyc("pause_on2", 0, 0, 1, 0);
        cyc("paused_bonus", 0, 0, 0, 1);
        cyc("pause_off2", 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) cyc("bonus_up", 0, 0, 0, 1);
        cyc("to98", 1, 0, 0, 0);
        cyc("to97", 1, 0, 0, 0);
        cyc("bonus_sat", 0, 0, 0, 1);
        cyc("tick_bonus_99", 1, 0, 0, 1);
        for (int i = 0; i < 98; i++) cyc("to1", 1, 0, 0, 0);
        cyc("tick_bonus_at1", 1, 0, 0, 1);

        // tick + pause at count 1: expiry wins over pause
        for (int i = 0; i < 4; i++) cyc("to1_again", 1, 0, 0, 0);
        cyc("tick_pause_at1", 1, 0, 1, 0);
        cyc("after_expiry", 0, 0, 0, 0);
        cyc("start_tick", 1, 1, 1, 1);

        // asynchronous reset mid-round at 23
        for (int i = 0; i < 37; i++) cyc("to23", 1, 0, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        sb_q.push_back(model_word());
        pop_check("async_rst");
        @(posedge clk);
        #1;
        sb_q.push_back(model_word());
        pop_check("rst_held");
        @(negedge clk);
        rst = 1'b0;
        cyc("post_rst_tick", 1, 0, 0, 0);
        cyc("post_rst_start", 0, 1, 0, 0);
        cyc("post_rst_run", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
